// File: rtl/lut_mult_seq_ctrl.sv
// lut_multiplier_2b: combinational SIZE x 2-bit product, forced to zero while
// reset is low.
//   reset  active-low reset; M reads 0 while asserted
//   A      SIZE-bit multiplicand
//   B      2-bit multiplier digit
//   M      SIZE+2-bit product A*B
//
// lut_mult_seq_ctrl: sequential SIZE x SIZE unsigned multiplier. It feeds one
// 2-bit digit of B per cycle, LSB digit first, into the shared
// lut_multiplier_2b and shift-adds the partial products into an accumulator.
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   start  request a multiply (sampled only in IDLE)
//   A, B   SIZE-bit operands, latched on an accepted start
//   busy   high whenever the state is not IDLE
//   done   one-cycle pulse, P valid while high
//   P      2*SIZE-bit product, held until the next accepted start

module lut_multiplier_2b #(
  parameter int unsigned SIZE = 8
) (
  input  logic            reset,
  input  logic [SIZE-1:0] A,
  input  logic [1:0]      B,
  output logic [SIZE+1:0] M
);

  localparam int unsigned MW = SIZE + 2;

  logic [MW-1:0] a_ext;

  assign a_ext = MW'(A);

  // Digit lookup: 0, A, 2A, 3A
  always_comb begin
    M = '0;
    if (reset) begin
      case (B)
        2'd1:    M = a_ext;
        2'd2:    M = a_ext << 1;
        2'd3:    M = (a_ext << 1) + a_ext;
        default: M = '0;
      endcase
    end
  end

endmodule

module lut_mult_seq_ctrl #(
  parameter int unsigned SIZE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SIZE-1:0]   A,
  input  logic [SIZE-1:0]   B,
  output logic              busy,
  output logic              done,
  output logic [2*SIZE-1:0] P
);

  localparam int unsigned PW     = 2 * SIZE;
  localparam int unsigned DIGITS = SIZE / 2;
  localparam int unsigned CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  // Odd or too-small widths cannot be split into 2-bit digits
  if ((SIZE % 2) != 0 || SIZE < 2) begin : g_bad_size
    $error("lut_mult_seq_ctrl: SIZE must be even and >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [SIZE-1:0] a_reg;
  logic [SIZE-1:0] b_reg;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;

  logic [CW:0]     shamt;
  logic [1:0]      digit;
  logic [SIZE+1:0] term;
  logic [PW-1:0]   acc_next;

  // Bit offset of the current digit is 2*cnt
  assign shamt    = {cnt, 1'b0};
  assign digit    = 2'(b_reg >> shamt);
  assign acc_next = acc + (PW'(term) << shamt);

  lut_multiplier_2b #(
    .SIZE (SIZE)
  ) u_lut (
    .reset (reset),
    .A     (a_reg),
    .B     (digit),
    .M     (term)
  );

  // Control FSM with registered busy/done/P
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      P     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= A;
            b_reg <= B;
            acc   <= '0;
            cnt   <= '0;
            P     <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          if (cnt == LAST) begin
            P     <= acc_next;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_mult_seq_ctrl.sv
// Scoreboard bench for lut_mult_seq_ctrl (SIZE=8 main instance, SIZE=2 corner
// instance). Expected products and acceptance cycles are queued by the driver;
// a monitor pops them whenever done is seen.

module tb_lut_mult_seq_ctrl;

  localparam int unsigned SIZE = 8;
  localparam int unsigned LAT  = SIZE / 2;

  logic              clk;
  logic              reset;
  logic              start;
  logic [SIZE-1:0]   A;
  logic [SIZE-1:0]   B;
  logic              busy;
  logic              done;
  logic [2*SIZE-1:0] P;

  logic       start2;
  logic [1:0] A2;
  logic [1:0] B2;
  logic       busy2;
  logic       done2;
  logic [3:0] P2;

  int tests;
  int fails;
  int cyc;

  int exp_q[$];
  int cyc_q[$];

  lut_mult_seq_ctrl #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  lut_mult_seq_ctrl #(.SIZE(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .start (start2),
    .A     (A2),
    .B     (B2),
    .busy  (busy2),
    .done  (done2),
    .P     (P2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding multiply
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        int e;
        int c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        chk("product", int'(P), e);
        chk("latency", cyc - c, LAT);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  // One start pulse from IDLE; operands are replaced by sa/sb after acceptance
  task automatic issue(input int a, input int b, input int sa, input int sb);
    @(negedge clk);
    A     = SIZE'(a);
    B     = SIZE'(b);
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(a * b);
    cyc_q.push_back(cyc);
    @(negedge clk);
    start = 1'b0;
    A     = SIZE'(sa);
    B     = SIZE'(sb);
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    cyc    = 0;
    start  = 1'b0;
    A      = '0;
    B      = '0;
    start2 = 1'b0;
    A2     = '0;
    B2     = '0;
    reset  = 1'b0;
    #3;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_P", int'(P), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // 13*11 with operands forced to all-ones during CALC; busy window of 5
    wait_idle();
    issue(13, 11, 255, 255);
    for (int i = 0; i < 6; i++) begin
      chk("busy_window", int'(busy), (i < 5) ? 1 : 0);
      @(negedge clk);
    end

    // Corner operands, constant latency
    wait_idle();
    issue(255, 255, 0, 0);
    wait_idle();
    issue(0, 200, 7, 7);
    wait_idle();
    issue(200, 0, 9, 9);

    // start held high: back-to-back accepts exactly 6 cycles apart
    wait_idle();
    @(negedge clk);
    A     = SIZE'(3);
    B     = SIZE'(7);
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(21);
    cyc_q.push_back(cyc);
    @(negedge clk);
    A = SIZE'(10);
    B = SIZE'(10);
    repeat (5) @(posedge clk);
    #1;
    chk("held_idle_gap", int'(busy), 0);
    @(posedge clk);
    #1;
    chk("held_reaccept", int'(busy), 1);
    exp_q.push_back(100);
    cyc_q.push_back(cyc);
    @(negedge clk);
    start = 1'b0;

    // Reset in the second CALC cycle aborts immediately
    wait_idle();
    @(negedge clk);
    A     = SIZE'(200);
    B     = SIZE'(150);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_P", int'(P), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_done_busy", int'(busy), 0);
    wait_idle();
    issue(6, 9, 1, 1);

    // Randomised multiplies with random idle gaps and operand scrambling
    for (int i = 0; i < 30; i++) begin
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    // SIZE=2: 3*3 in one CALC cycle
    @(negedge clk);
    A2     = 2'd3;
    B2     = 2'd3;
    start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    A2     = 2'd0;
    B2     = 2'd0;
    chk("s2_busy", int'(busy2), 1);
    chk("s2_done_early", int'(done2), 0);
    @(negedge clk);
    chk("s2_done", int'(done2), 1);
    chk("s2_P", int'(P2), 9);
    @(negedge clk);
    chk("s2_idle", int'(busy2), 0);
    chk("s2_P_hold", int'(P2), 9);

    // Drain
    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
